dvp_capture_writer: RTL and testbench
=====================================

Name: dvp_capture_writer

Overview:
- Camera-side front end that fills the raw-pixel FIFO consumed by the ISP/bypass pipeline (the FIFO's 8-bit data, empty and read side).
- Samples a DVP sensor bus (pclk, vsync, href, data) inside the HCLK domain, crops each frame to h_active × v_active and pushes 8-bit Bayer pixels into the FIFO write port.
- Runs single-shot per capture_start. Reports frame completion, short frames and FIFO overflow to firmware.

Parameters:
- DATA_W, 8, pixel width on cam_data and fifo_wdata.
- CNT_W, 12, width of the column/line counters and of the h_active/v_active inputs.
- SYNC_STAGES, 2, synchroniser depth on all cam_* inputs (minimum 2).

Ports:
- HCLK  in  1  system clock; all logic on its rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- cam_pclk  in  1  sensor pixel clock; treated as data and sampled by HCLK. Must be < HCLK/4.
- cam_vsync  in  1  frame sync, active high during vertical blanking.
- cam_href  in  1  line valid, active high.
- cam_data  in  DATA_W  sensor pixel data.
- capture_start  in  1  one-cycle pulse; arms capture of the next frame.
- h_active_in  in  CNT_W  pixels written per line.
- v_active_in  in  CNT_W  lines written per frame.
- fifo_full  in  1  FIFO cannot accept a write this cycle.
- overflow_clr  in  1  clears the overflow flag.
- fifo_wr  out  1  FIFO write strobe, one cycle per pixel.
- fifo_wdata  out  DATA_W  pixel written with fifo_wr.
- busy  out  1  high in ARM and ACTIVE.
- frame_done  out  1  one-cycle pulse when a capture ends.
- short_frame  out  1  last capture ended before v_active lines; held until the next capture_start.
- overflow  out  1  sticky; a pixel was dropped because fifo_full was high.
- line_cnt  out  CNT_W  lines written in the current/last frame.

Behaviour:
- Reset values: fifo_wr=0, fifo_wdata=0, busy=0, frame_done=0, short_frame=0, overflow=0, line_cnt=0, col=0, FSM=IDLE. Synchroniser flops reset to 0.
- Reset asserted mid-frame aborts the capture immediately. No frame_done is generated.
- Synchronisation:
  - cam_pclk, cam_vsync, cam_href and cam_data pass through identical SYNC_STAGES flop chains, so they stay aligned.
  - Edge detects use one further register on each synced signal.
  - Pixel strobe = rising edge of synced pclk.
- The latched h_active/v_active (lat_h/lat_v) are captured on the accepted capture_start and stay constant for the whole frame.
- FSM IDLE:
  - capture_start with h_active_in≠0 and v_active_in≠0 → ARM.
  - On that transition: latch h_active/v_active, clear short_frame and line_cnt.
  - capture_start is ignored if either input is 0.
- FSM ARM: wait for a synced vsync falling edge → ACTIVE, col=0. Any line already in progress is never captured partially.
- FSM ACTIVE, on a pixel strobe with synced href=1:
  - If col<lat_h: register fifo_wdata and assert fifo_wr the next cycle. Strobe-to-fifo_wr latency is 1 HCLK.
  - col saturates at lat_h; extra pixels are discarded.
- FSM ACTIVE, on an href falling edge with col≠0: line_cnt++, col=0. If line_cnt+1==lat_v → DONE.
- FSM ACTIVE, on a vsync rising edge: → DONE with short_frame=1, unless the same cycle's href fall completes line lat_v; in that case short_frame=0.
- FSM DONE: frame_done=1 for one cycle → IDLE.
- capture_start is ignored while busy or in DONE.
- Overflow:
  - A write attempted while fifo_full=1 does not assert fifo_wr; the pixel is dropped, col still increments, and overflow is set.
  - When overflow_clr and a new drop occur in the same cycle, overflow stays 1 (set wins).
- A short line (href falls with col<lat_h) still counts as a line. No padding is inserted.
- Counters are CNT_W wide with no wrap: col stops at lat_h, and line_cnt stops at lat_v because the FSM leaves ACTIVE.

Test Plan:
- Reset, then capture_start with h=16, v=16; DVP frame of 20×18 after one vsync → exactly 256 fifo_wr pulses with data matching cols 0–15 of lines 0–15, frame_done once, line_cnt=16, short_frame=0.
- capture_start issued mid-frame (href active) → nothing is written until the next vsync fall; the following frame is captured intact.
- h=8, v=4, fifo_full held high for pixels 3–5 of line 1 → 29 writes, overflow=1 and stays 1 until overflow_clr; a set on the same cycle as overflow_clr wins.
- h=8, v=10, sensor emits 6 lines then vsync rises → frame_done, short_frame=1, line_cnt=6.
- capture_start with h=0 → remains IDLE, busy=0, no fifo_wr; a second capture_start while busy is ignored.
- HRESETn pulsed low during line 3 → all outputs 0 asynchronously, no frame_done; a new capture then works normally.

Source files
------------

// File: rtl/dvp_capture_writer.sv
// rtl/dvp_capture_writer.sv - DVP sensor sampler that crops frames and writes raw pixels into the ISP input FIFO
// The whole DVP bus, pclk included, is sampled as plain data in the HCLK domain.
module dvp_capture_writer #(
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [DATA_W-1:0] cam_data,
  input  logic              capture_start,
  input  logic [CNT_W-1:0]  h_active_in,
  input  logic [CNT_W-1:0]  v_active_in,
  input  logic              fifo_full,
  input  logic              overflow_clr,
  output logic              fifo_wr,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic              short_frame,
  output logic              overflow,
  output logic [CNT_W-1:0]  line_cnt
);

  typedef enum logic [1:0] {IDLE, ARM, ACTIVE, DONE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0]             pclk_sync, vsync_sync, href_sync;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] data_sync;
  logic                               pclk_d, vsync_d, href_d;
  logic                               pclk_s, vsync_s, href_s;
  logic [DATA_W-1:0]                  data_s;

  logic [CNT_W-1:0] col, lat_h, lat_v, line_inc;
  logic             pix_strobe, vsync_fall, vsync_rise, href_fall;
  logic             pix_take, line_end, last_line;
  logic             start_ok, enter_active, set_short;

  // Identical chain depth on every cam_* bit keeps data aligned with the pclk edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pclk_sync  <= '0;
      vsync_sync <= '0;
      href_sync  <= '0;
      data_sync  <= '0;
      pclk_d     <= 1'b0;
      vsync_d    <= 1'b0;
      href_d     <= 1'b0;
    end else begin
      pclk_sync  <= {pclk_sync[SYNC_STAGES-2:0], cam_pclk};
      vsync_sync <= {vsync_sync[SYNC_STAGES-2:0], cam_vsync};
      href_sync  <= {href_sync[SYNC_STAGES-2:0], cam_href};
      data_sync  <= {data_sync[SYNC_STAGES-2:0], cam_data};
      pclk_d     <= pclk_s;
      vsync_d    <= vsync_s;
      href_d     <= href_s;
    end
  end

  assign pclk_s  = pclk_sync[SYNC_STAGES-1];
  assign vsync_s = vsync_sync[SYNC_STAGES-1];
  assign href_s  = href_sync[SYNC_STAGES-1];
  assign data_s  = data_sync[SYNC_STAGES-1];

  assign pix_strobe = pclk_s & ~pclk_d;
  assign vsync_fall = vsync_d & ~vsync_s;
  assign vsync_rise = vsync_s & ~vsync_d;
  assign href_fall  = href_d & ~href_s;

  assign line_inc     = line_cnt + 1'b1;
  assign pix_take     = (state == ACTIVE) && pix_strobe && href_s && (col < lat_h);
  assign line_end     = (state == ACTIVE) && href_fall && (col != '0);
  assign last_line    = line_end && (line_inc == lat_v);
  assign enter_active = (state == ARM) && vsync_fall;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    set_short = 1'b0;
    case (state)
      IDLE: begin
        if (capture_start && (h_active_in != '0) && (v_active_in != '0)) begin
          state_nxt = ARM;
          start_ok  = 1'b1;
        end
      end
      ARM: begin
        if (vsync_fall) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        // Completing the final line outranks a coincident vsync rise.
        if (last_line) begin
          state_nxt = DONE;
        end else if (vsync_rise) begin
          state_nxt = DONE;
          set_short = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      lat_h       <= '0;
      lat_v       <= '0;
      col         <= '0;
      line_cnt    <= '0;
      short_frame <= 1'b0;
      fifo_wr     <= 1'b0;
      fifo_wdata  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (start_ok) begin
        lat_h       <= h_active_in;
        lat_v       <= v_active_in;
        line_cnt    <= '0;
        short_frame <= 1'b0;
      end else if (set_short) begin
        short_frame <= 1'b1;
      end

      if (enter_active) begin
        col <= '0;
      end else if (line_end) begin
        col      <= '0;
        line_cnt <= line_inc;
      end else if (pix_take) begin
        col <= col + 1'b1;
      end

      fifo_wr <= pix_take & ~fifo_full;
      if (pix_take && !fifo_full) fifo_wdata <= data_s;

      if (pix_take && fifo_full) overflow <= 1'b1;
      else if (overflow_clr)     overflow <= 1'b0;
    end
  end

  assign busy       = (state == ARM) || (state == ACTIVE);
  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_dvp_capture_writer.sv
// tb/tb_dvp_capture_writer.sv - table-driven directed bench for dvp_capture_writer
module tb_dvp_capture_writer;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 12;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic              cam_pclk, cam_vsync, cam_href;
  logic [DATA_W-1:0] cam_data;
  logic              capture_start;
  logic [CNT_W-1:0]  h_active_in, v_active_in;
  logic              fifo_full, overflow_clr;
  logic              fifo_wr;
  logic [DATA_W-1:0] fifo_wdata;
  logic              busy, frame_done, short_frame, overflow;
  logic [CNT_W-1:0]  line_cnt;

  always #5 HCLK = ~HCLK;

  dvp_capture_writer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .capture_start(capture_start), .h_active_in(h_active_in), .v_active_in(v_active_in),
    .fifo_full(fifo_full), .overflow_clr(overflow_clr),
    .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .busy(busy), .frame_done(frame_done),
    .short_frame(short_frame), .overflow(overflow), .line_cnt(line_cnt)
  );

  typedef struct {
    int h, v, cols, lines;
    int drop_line, drop_first, drop_last, clr_col;
    bit vs_on_fall;
    int exp_wr, exp_lines;
    bit exp_short, exp_ovf;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  logic [7:0] got_q[$];

  int drop_line, drop_first, drop_last, clr_col, start_line;
  bit vs_fall_flag;

  always @(negedge HCLK) begin
    if (fifo_wr) got_q.push_back(fifo_wdata);
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int l, input int c);
    return 8'((l * 20 + c) & 255);
  endfunction

  function automatic int data_mism(input int nc, input int nl);
    logic [7:0] exp_q[$];
    int m = 0;
    for (int l = 0; l < nl; l++)
      for (int c = 0; c < nc; c++)
        if (!(l == drop_line && c >= drop_first && c <= drop_last)) exp_q.push_back(pix(l, c));
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) m++;
    return m;
  endfunction

  task automatic pixel(input logic [7:0] d, input bit full, input bit clr_hit);
    cam_data  = d;
    fifo_full = full;
    repeat (4) @(negedge HCLK);
    cam_pclk = 1'b1;
    if (clr_hit) begin
      // The strobe lands on the third rising edge after pclk goes high.
      repeat (2) @(negedge HCLK);
      overflow_clr = 1'b1;
      @(negedge HCLK);
      overflow_clr = 1'b0;
      check("ovf_set_wins", overflow, 1);
      @(negedge HCLK);
    end else begin
      repeat (4) @(negedge HCLK);
    end
    cam_pclk  = 1'b0;
    fifo_full = 1'b0;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) pixel(8'h00, 1'b0, 1'b0);
  endtask

  task automatic pulse_start();
    capture_start = 1'b1;
    @(negedge HCLK);
    capture_start = 1'b0;
  endtask

  task automatic send_line(input int l, input int cols, input bit last_vs);
    cam_href = 1'b1;
    for (int c = 0; c < cols; c++) begin
      if (l == start_line && c == 2) pulse_start();
      pixel(pix(l, c), (l == drop_line && c >= drop_first && c <= drop_last),
            (l == drop_line && c == clr_col));
    end
    cam_href = 1'b0;
    if (last_vs) cam_vsync = 1'b1;
    blank(2);
  endtask

  task automatic send_frame(input int cols, input int lines);
    cam_vsync = 1'b1;
    blank(3);
    cam_vsync = 1'b0;
    blank(2);
    for (int l = 0; l < lines; l++) send_line(l, cols, vs_fall_flag && (l == lines - 1));
    cam_vsync = 1'b1;
    blank(3);
  endtask

  task automatic set_plain(input int h, input int v);
    drop_line = -1; drop_first = 0; drop_last = -1; clr_col = -1;
    start_line = -1; vs_fall_flag = 1'b0;
    h_active_in = CNT_W'(h);
    v_active_in = CNT_W'(v);
    got_q.delete();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int fd0;
    drop_line = v.drop_line; drop_first = v.drop_first; drop_last = v.drop_last;
    clr_col = v.clr_col; start_line = -1; vs_fall_flag = v.vs_on_fall;
    h_active_in = CNT_W'(v.h);
    v_active_in = CNT_W'(v.v);
    got_q.delete();
    fd0 = fd_cnt;
    pulse_start();
    @(negedge HCLK);
    check({tag, "_busy"}, busy, 1);
    send_frame(v.cols, v.lines);
    repeat (10) @(negedge HCLK);
    check({tag, "_writes"}, got_q.size(), v.exp_wr);
    check({tag, "_data"}, data_mism(v.cols < v.h ? v.cols : v.h, v.lines < v.v ? v.lines : v.v), 0);
    check({tag, "_frame_done"}, fd_cnt - fd0, 1);
    check({tag, "_line_cnt"}, line_cnt, v.exp_lines);
    check({tag, "_short"}, short_frame, v.exp_short);
    check({tag, "_overflow"}, overflow, v.exp_ovf);
    check({tag, "_idle"}, busy, 0);
    if (v.exp_ovf) begin
      overflow_clr = 1'b1;
      @(negedge HCLK);
      overflow_clr = 1'b0;
      @(negedge HCLK);
      check({tag, "_ovf_clr"}, overflow, 0);
    end
  endtask

  vec_t vecs [5];
  vec_t post_rst;

  initial begin
    int fd0;
    vecs[0] = '{16, 16, 20, 18, -1, 0, -1, -1, 1'b0, 256, 16, 1'b0, 1'b0};
    vecs[1] = '{8, 4, 10, 5, 1, 3, 5, 5, 1'b0, 29, 4, 1'b0, 1'b1};
    vecs[2] = '{8, 10, 8, 6, -1, 0, -1, -1, 1'b0, 48, 6, 1'b1, 1'b0};
    vecs[3] = '{4, 3, 4, 3, -1, 0, -1, -1, 1'b1, 12, 3, 1'b0, 1'b0};
    vecs[4] = '{8, 4, 5, 4, -1, 0, -1, -1, 1'b0, 20, 4, 1'b0, 1'b0};
    post_rst = '{4, 2, 6, 3, -1, 0, -1, -1, 1'b0, 8, 2, 1'b0, 1'b0};

    HRESETn = 1'b0;
    cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = '0;
    capture_start = 1'b0; fifo_full = 1'b0; overflow_clr = 1'b0;
    set_plain(0, 0);
    repeat (3) @(negedge HCLK);
    check("reset_outputs", {fifo_wr, busy, frame_done, short_frame, overflow, fifo_wdata, line_cnt}, 0);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // h=0 must not arm
    set_plain(0, 4);
    fd0 = fd_cnt;
    pulse_start();
    @(negedge HCLK);
    check("h0_busy", busy, 0);
    send_frame(8, 4);
    repeat (10) @(negedge HCLK);
    check("h0_writes", got_q.size(), 0);
    check("h0_frame_done", fd_cnt - fd0, 0);

    // second start while armed keeps the first geometry
    set_plain(4, 2);
    fd0 = fd_cnt;
    pulse_start();
    h_active_in = 12'd8;
    v_active_in = 12'd8;
    @(negedge HCLK);
    pulse_start();
    send_frame(10, 4);
    repeat (10) @(negedge HCLK);
    check("ign_writes", got_q.size(), 8);
    check("ign_data", data_mism(4, 2), 0);
    check("ign_line_cnt", line_cnt, 2);
    check("ign_frame_done", fd_cnt - fd0, 1);

    // start issued mid-line waits for the next vsync fall
    set_plain(8, 2);
    start_line = 1;
    fd0 = fd_cnt;
    send_frame(10, 4);
    repeat (10) @(negedge HCLK);
    check("mid_armed", busy, 1);
    check("mid_no_writes", got_q.size(), 0);
    check("mid_no_done", fd_cnt - fd0, 0);
    start_line = -1;
    send_frame(10, 4);
    repeat (10) @(negedge HCLK);
    check("mid_writes", got_q.size(), 16);
    check("mid_data", data_mism(8, 2), 0);
    check("mid_line_cnt", line_cnt, 2);
    check("mid_frame_done", fd_cnt - fd0, 1);

    // asynchronous reset during line 3
    set_plain(8, 8);
    fd0 = fd_cnt;
    pulse_start();
    cam_vsync = 1'b1; blank(3);
    cam_vsync = 1'b0; blank(2);
    for (int l = 0; l < 3; l++) send_line(l, 10, 1'b0);
    cam_href = 1'b1;
    for (int c = 0; c < 3; c++) pixel(pix(3, c), 1'b0, 1'b0);
    check("rst_pre_lines", line_cnt, 3);
    check("rst_pre_busy", busy, 1);
    #3 HRESETn = 1'b0;
    got_q.delete();
    #1;
    check("rst_async", {fifo_wr, busy, frame_done, short_frame, overflow, fifo_wdata, line_cnt}, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int c = 3; c < 10; c++) pixel(pix(3, c), 1'b0, 1'b0);
    cam_href = 1'b0; blank(2);
    cam_vsync = 1'b1; blank(3);
    repeat (10) @(negedge HCLK);
    check("rst_no_writes", got_q.size(), 0);
    check("rst_no_done", fd_cnt - fd0, 0);
    run_vec(post_rst, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
